// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide controller and owner of the architectural HI/LO registers.
// Multiplies run locally in two cycles; divides are handed to an external radix-2 divider.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        ex_stall,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_valid,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_flush,
    input  logic        div_busy,
    input  logic [63:0] div_result
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_WAIT,
        S_MUL,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [32:0] mul_a_reg, mul_a_next;
    logic [32:0] mul_b_reg, mul_b_next;
    logic [31:0] hi_next, lo_next;
    logic [63:0] mul_a_ext, mul_b_ext;
    logic [63:0] prod;

    // Only the low 64 bits of the 66-bit signed product reach HI/LO, and those
    // bits are identical to the 64-bit product of the sign-extended operands.
    assign mul_a_ext = {{31{mul_a_reg[32]}}, mul_a_reg};
    assign mul_b_ext = {{31{mul_b_reg[32]}}, mul_b_reg};
    assign prod      = mul_a_ext * mul_b_ext;

    assign div_flush = flush;

    always_comb begin
        state_next = state_reg;
        mul_a_next = mul_a_reg;
        mul_b_next = mul_b_reg;
        hi_next    = hi_o;
        lo_next    = lo_o;
        ex_stall   = 1'b0;
        div_valid  = 1'b0;
        div_sign   = 1'b0;
        div_a      = 32'd0;
        div_b      = 32'd0;

        case (state_reg)
            S_IDLE: begin
                if (!flush) begin
                    case (op)
                        OP_DIV, OP_DIVU: begin
                            div_valid  = 1'b1;
                            div_sign   = (op == OP_DIV);
                            div_a      = rs_val;
                            div_b      = rt_val;
                            ex_stall   = 1'b1;
                            state_next = S_DIV_WAIT;
                        end
                        OP_MULT: begin
                            mul_a_next = {rs_val[31], rs_val};
                            mul_b_next = {rt_val[31], rt_val};
                            ex_stall   = 1'b1;
                            state_next = S_MUL;
                        end
                        OP_MULTU: begin
                            mul_a_next = {1'b0, rs_val};
                            mul_b_next = {1'b0, rt_val};
                            ex_stall   = 1'b1;
                            state_next = S_MUL;
                        end
                        OP_MTHI: hi_next = rs_val;
                        OP_MTLO: lo_next = rs_val;
                        default: ;
                    endcase
                end
            end
            S_DIV_WAIT: begin
                if (div_busy) begin
                    ex_stall = 1'b1;
                end else begin
                    hi_next    = div_result[63:32];
                    lo_next    = div_result[31:0];
                    state_next = ex_hold ? S_DONE : S_IDLE;
                end
            end
            S_MUL: begin
                hi_next    = prod[63:32];
                lo_next    = prod[31:0];
                state_next = ex_hold ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                // Committed instruction still sits in EX; wait for it to leave.
                if (!ex_hold) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (flush) begin
            state_next = S_IDLE;
            hi_next    = hi_o;
            lo_next    = lo_o;
            div_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            mul_a_reg <= 33'd0;
            mul_b_reg <= 33'd0;
            hi_o      <= 32'd0;
            lo_o      <= 32'd0;
        end else begin
            state_reg <= state_next;
            mul_a_reg <= mul_a_next;
            mul_b_reg <= mul_b_next;
            hi_o      <= hi_next;
            lo_o      <= lo_next;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: behavioural 32-cycle divider, directed vectors, and a
// scoreboard monitor that checks HI/LO after every mul/div commit.
module tb_hilo_muldiv;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_hold = 1'b0;
    logic [2:0]  op = OP_NONE;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        ex_stall;
    logic [31:0] hi_o, lo_o;
    logic        div_valid, div_sign, div_flush;
    logic [31:0] div_a, div_b;
    logic        div_busy = 1'b0;
    logic [63:0] div_result = 64'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hilo_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ex_hold    (ex_hold),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .ex_stall   (ex_stall),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_valid  (div_valid),
        .div_sign   (div_sign),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_flush  (div_flush),
        .div_busy   (div_busy),
        .div_result (div_result)
    );

    // Divider environment model: busy for exactly 32 cycles after a start.
    function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sq, sr;
        logic [31:0] uq, ur;
        if (s) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    logic [5:0]  dcnt = 6'd0;
    logic [63:0] dpend = 64'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_result <= 64'd0;
        end
        if (rst || div_flush) begin
            div_busy <= 1'b0;
            dcnt     <= 6'd0;
        end else if (!div_busy && div_valid) begin
            div_busy <= 1'b1;
            dcnt     <= 6'd32;
            dpend    <= div_model(div_sign, div_a, div_b);
        end else if (div_busy) begin
            dcnt <= dcnt - 6'd1;
            if (dcnt == 6'd1) begin
                div_busy   <= 1'b0;
                div_result <= dpend;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sbq[$];

    // Monitor: a stall that ends without flush/reset marks a commit cycle;
    // HI/LO are compared one cycle later, after the commit edge.
    logic mon_prev_stall = 1'b0;
    logic mon_prev_kill  = 1'b0;
    logic mon_pending    = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mon_pending) begin
            mon_pending = 1'b0;
            if (sbq.size() == 0) begin
                check("unexpected commit", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                $display("commit %s: hi=0x%08h lo=0x%08h (want hi=0x%08h lo=0x%08h)",
                         e.name, hi_o, lo_o, e.hi, e.lo);
                check({e.name, " hi"}, {32'd0, hi_o}, {32'd0, e.hi});
                check({e.name, " lo"}, {32'd0, lo_o}, {32'd0, e.lo});
            end
        end
        if (mon_prev_stall && !ex_stall && !mon_prev_kill) begin
            mon_pending = 1'b1;
        end
        mon_prev_stall = ex_stall;
        mon_prev_kill  = flush | rst;
    end

    logic        iss_valid, iss_sign;
    logic [31:0] iss_a, iss_b;

    // Issue an op and count stall cycles; returns sampled in the commit cycle.
    task automatic issue_and_count(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output int cnt);
        @(negedge clk);
        op = o;
        rs_val = a;
        rt_val = b;
        #1;
        iss_valid = div_valid;
        iss_sign  = div_sign;
        iss_a     = div_a;
        iss_b     = div_b;
        cnt = 0;
        while (ex_stall && cnt < 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        exp_t e;
        e.name = name;
        e.hi   = exp_hi;
        e.lo   = exp_lo;
        sbq.push_back(e);
        issue_and_count(o, a, b, cnt);
        $display("issue %s: op=%0d rs=0x%08h rt=0x%08h stall_cycles=%0d", name, o, a, b, cnt);
        check({name, " stall cycles"}, 64'(cnt), 64'(exp_stall));
        @(negedge clk);
        op = OP_NONE;
        rs_val = 32'd0;
        rt_val = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        exp_t e;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset hi_o", {32'd0, hi_o}, 64'd0);
        check("reset lo_o", {32'd0, lo_o}, 64'd0);
        check("reset ex_stall", {63'd0, ex_stall}, 64'd0);
        check("reset div_valid", {63'd0, div_valid}, 64'd0);
        check("reset div_sign", {63'd0, div_sign}, 64'd0);
        check("reset div_a", {32'd0, div_a}, 64'd0);
        check("reset div_b", {32'd0, div_b}, 64'd0);

        run_op("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check("DIV issue div_valid", {63'd0, iss_valid}, 64'd1);
        check("DIV issue div_sign", {63'd0, iss_sign}, 64'd1);
        check("DIV issue div_a", {32'd0, iss_a}, 64'hFFFFFFF9);
        check("DIV issue div_b", {32'd0, iss_b}, 64'd2);

        run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        check("DIVU issue div_sign", {63'd0, iss_sign}, 64'd0);

        run_op("MULTU max*max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001);
        check("MULTU issue div_valid", {63'd0, iss_valid}, 64'd0);
        run_op("MULT -1*-1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 32'h00000001);
        run_op("MULT -3*5", OP_MULT, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("MULT 0x40000000*4", OP_MULT, 32'h40000000, 32'd4, 1, 32'h00000001, 32'h00000000);

        // Flush a DIVU on its 10th DIV_WAIT cycle.
        @(negedge clk);
        op = OP_DIVU;
        rs_val = 32'd200;
        rt_val = 32'd3;
        repeat (10) @(negedge clk);
        #1;
        check("flush: stall before flush", {63'd0, ex_stall}, 64'd1);
        flush = 1'b1;
        #1;
        check("flush: div_flush", {63'd0, div_flush}, 64'd1);
        check("flush: div_valid", {63'd0, div_valid}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        op = OP_NONE;
        #1;
        $display("flush DIVU 200/3: ex_stall=%0b hi=0x%08h lo=0x%08h", ex_stall, hi_o, lo_o);
        check("flush: ex_stall after", {63'd0, ex_stall}, 64'd0);
        check("flush: hi unchanged", {32'd0, hi_o}, 64'h00000001);
        check("flush: lo unchanged", {32'd0, lo_o}, 64'h00000000);
        run_op("DIVU 1000/9 after flush", OP_DIVU, 32'd1000, 32'd9, 33, 32'd1, 32'd111);

        // DIV commits while EX is held for 3 cycles with op still DIV.
        e.name = "DIV -100/7 held";
        e.hi   = 32'hFFFFFFFE;
        e.lo   = 32'hFFFFFFF2;
        sbq.push_back(e);
        issue_and_count(OP_DIV, 32'hFFFFFF9C, 32'd7, cnt);
        $display("issue DIV -100/7 held: stall_cycles=%0d", cnt);
        check("held DIV stall cycles", 64'(cnt), 64'd33);
        ex_hold = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("held DONE div_valid", {63'd0, div_valid}, 64'd0);
            check("held DONE ex_stall", {63'd0, ex_stall}, 64'd0);
        end
        @(negedge clk);
        ex_hold = 1'b0;
        #1;
        check("held last DONE div_valid", {63'd0, div_valid}, 64'd0);
        check("held last DONE ex_stall", {63'd0, ex_stall}, 64'd0);
        @(negedge clk);
        op = OP_NONE;
        #1;
        check("held back in IDLE ex_stall", {63'd0, ex_stall}, 64'd0);
        check("held back in IDLE lo", {32'd0, lo_o}, 64'hFFFFFFF2);

        // MTHI / MTLO, read back by the next instruction.
        @(negedge clk);
        op = OP_MTHI;
        rs_val = 32'h12345678;
        #1;
        check("MTHI no stall", {63'd0, ex_stall}, 64'd0);
        @(negedge clk);
        op = OP_NONE;
        rs_val = 32'd0;
        #1;
        $display("MTHI 0x12345678: hi=0x%08h lo=0x%08h", hi_o, lo_o);
        check("MTHI hi", {32'd0, hi_o}, 64'h12345678);
        check("MTHI lo unchanged", {32'd0, lo_o}, 64'hFFFFFFF2);
        @(negedge clk);
        op = OP_MTLO;
        rs_val = 32'hCAFEF00D;
        @(negedge clk);
        op = OP_NONE;
        rs_val = 32'd0;
        #1;
        $display("MTLO 0xCAFEF00D: hi=0x%08h lo=0x%08h", hi_o, lo_o);
        check("MTLO lo", {32'd0, lo_o}, 64'hCAFEF00D);
        check("MTLO hi unchanged", {32'd0, hi_o}, 64'h12345678);

        // Reset in the middle of DIV_WAIT.
        @(negedge clk);
        op = OP_DIV;
        rs_val = 32'd50;
        rt_val = 32'd3;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op = OP_NONE;
        #1;
        $display("reset mid-DIV: ex_stall=%0b hi=0x%08h lo=0x%08h", ex_stall, hi_o, lo_o);
        check("mid reset hi", {32'd0, hi_o}, 64'd0);
        check("mid reset lo", {32'd0, lo_o}, 64'd0);
        check("mid reset ex_stall", {63'd0, ex_stall}, 64'd0);
        run_op("MULTU 3*5 after reset", OP_MULTU, 32'd3, 32'd5, 1, 32'd0, 32'd15);

        repeat (4) @(negedge clk);
        #3;
        check("scoreboard drained", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
